// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the pipelined adder/subtractor:
//   MODE_ADD / MODE_SUB  encodings of the per-beat mode bit (in_sub)
//   num_stages()         pipeline depth for a given width and chunk size
//   signed_max/min()     two's-complement extremes of a given width, used by
//                        the optional saturating output
// -----------------------------------------------------------------------------
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // ceil(width / chunk): one carry-resolving stage per chunk.
    function automatic int num_stages(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    // 0111..1 in the low 'width' bits.
    function automatic logic [63:0] signed_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // 1000..0 in the low 'width' bits.
    function automatic logic [63:0] signed_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
// Combinational N-bit slice of the carry chain.
// Ports:
//   a, b     in   N   operand slices (b already inverted for subtraction)
//   cin      in   1   carry into bit 0 of the slice
//   sum      out  N   slice sum
//   cout     out  1   carry out of the top bit of the slice
//   cin_msb  out  1   carry into the top bit of the slice (for overflow detection)
// -----------------------------------------------------------------------------
module addsub_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         cin_msb
);

    logic [N:0] total;

    assign total   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign sum     = total[N-1:0];
    assign cout    = total[N];
    // The sum bit is a ^ b ^ carry-in, so the carry into the top bit falls out
    // of the operand bits and the sum bit without a second adder.
    assign cin_msb = a[N-1] ^ b[N-1] ^ total[N-1];

endmodule

// File: rtl/pipe_addsub.sv
// -----------------------------------------------------------------------------
// pipe_addsub
// Pipelined two's-complement adder/subtractor with valid/ready flow control.
// The carry chain is cut into CHUNK-bit slices; each pipeline stage resolves
// one slice. Operands are captured in an input rank, then STAGES slice stages
// follow, the last of which loads the output registers. A beat accepted at
// clock edge N is presented on out_* after edge N+STAGES.
//
// Configuration macro: PIPE_ADDSUB_SAT_EN
//   defined   -> on signed overflow the result clamps to signed max/min
//   undefined -> raw modulo-2^WIDTH result, no clamp logic
//
// Ports:
//   clk         in   1      clock, rising edge
//   rst_n       in   1      synchronous active-low reset
//   in_valid    in   1      operand beat valid
//   in_ready    out  1      beat accepted this cycle
//   in_a        in   WIDTH  minuend / augend
//   in_b        in   WIDTH  subtrahend / addend
//   in_sub      in   1      MODE_SUB: a-b, MODE_ADD: a+b
//   out_valid   out  1      result beat valid
//   out_ready   in   1      consumer accepts result this cycle
//   out_result  out  WIDTH  result modulo 2^WIDTH (or clamped, see above)
//   out_cb      out  1      add: carry-out; sub: borrow (a < b unsigned)
//   out_ovf     out  1      signed overflow
//
// Handshake: a beat moves across a port on a rising edge where valid and ready
// are both high. The whole pipeline advances together when adv = ~out_valid |
// out_ready, and in_ready = adv, so in_ready has a combinational path from
// out_ready. While out_valid=1 and out_ready=0 every register, including
// out_*, holds. Empty slots (valid=0) travel through like ordinary beats.
// -----------------------------------------------------------------------------
module pipe_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cb,
    output logic             out_ovf
);

    localparam int STAGES = num_stages(WIDTH, CHUNK);
    localparam int LAST   = STAGES - 1;

    logic adv;

    // Rank k feeds slice stage k. Rank 0 holds the captured operands.
    logic             v_r [STAGES];   // beat valid
    logic             s_r [STAGES];   // mode bit, needed to form carry/borrow
    logic             c_r [STAGES];   // carry into this rank's slice
    logic [WIDTH-1:0] a_r [STAGES];   // a, upper slices still unresolved
    logic [WIDTH-1:0] b_r [STAGES];   // effective b (inverted for sub)
    logic [WIDTH-1:0] r_r [STAGES];   // lower result slices already resolved

    // Combinational outputs of each slice stage.
    logic             c_n    [STAGES];
    logic             cmsb_n [STAGES];
    logic [WIDTH-1:0] r_n    [STAGES];

    logic [WIDTH-1:0] res_final;
    logic             res_cb;
    logic             res_ovf;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        // The last slice is narrower when CHUNK does not divide WIDTH.
        localparam int W  = ((WIDTH - LO) < CHUNK) ? (WIDTH - LO) : CHUNK;
        localparam logic [WIDTH-1:0] MASK = WIDTH'({W{1'b1}}) << LO;

        logic [W-1:0] sum;

        addsub_chunk #(.N(W)) u_chunk (
            .a       (a_r[k][LO +: W]),
            .b       (b_r[k][LO +: W]),
            .cin     (c_r[k]),
            .sum     (sum),
            .cout    (c_n[k]),
            .cin_msb (cmsb_n[k])
        );

        assign r_n[k] = (r_r[k] & ~MASK) | (WIDTH'(sum) << LO);
    end

    // The last slice holds the MSB, so its carries give the flags.
    assign res_ovf = cmsb_n[LAST] ^ c_n[LAST];
    assign res_cb  = (s_r[LAST] == MODE_SUB) ? ~c_n[LAST] : c_n[LAST];

`ifdef PIPE_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = WIDTH'(signed_max(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(signed_min(WIDTH));

    // On overflow the wrapped sign bit is the opposite of the true sign:
    // a set MSB means the true result was too large positive.
    assign res_final = !res_ovf ? r_n[LAST] : (r_n[LAST][WIDTH-1] ? SMAX : SMIN);
`else
    assign res_final = r_n[LAST];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k] <= 1'b0;
                s_r[k] <= 1'b0;
                c_r[k] <= 1'b0;
                a_r[k] <= '0;
                b_r[k] <= '0;
                r_r[k] <= '0;
            end
            out_valid  <= 1'b0;
            out_result <= '0;
            out_cb     <= 1'b0;
            out_ovf    <= 1'b0;
        end else if (adv) begin
            // Subtraction is a + ~b + 1: invert b and use the mode as carry-in.
            v_r[0] <= in_valid;
            s_r[0] <= in_sub;
            c_r[0] <= (in_sub == MODE_SUB);
            a_r[0] <= in_a;
            b_r[0] <= (in_sub == MODE_SUB) ? ~in_b : in_b;
            r_r[0] <= '0;
            for (int k = 1; k < STAGES; k++) begin
                v_r[k] <= v_r[k-1];
                s_r[k] <= s_r[k-1];
                c_r[k] <= c_n[k-1];
                a_r[k] <= a_r[k-1];
                b_r[k] <= b_r[k-1];
                r_r[k] <= r_n[k-1];
            end
            out_valid  <= v_r[LAST];
            out_result <= res_final;
            out_cb     <= res_cb;
            out_ovf    <= res_ovf;
        end
    end

endmodule
